// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_pkg
// Brief    : Shared state encoding and limits for the multiport register file
// Revision : 1.0
// ============================================================================
package regfile_pkg;

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } rf_state_e;

   localparam int MAX_RD = 4;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_read_port.sv
`default_nettype none
// ============================================================================
// Module   : regfile_read_port
// Brief    : One combinational read port: zero/range check, bypass, array mux
// Revision : 1.0
// ============================================================================
module regfile_read_port
   import regfile_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int NREGS  = 32,
   parameter int AW     = $clog2(NREGS),
   parameter int BYPASS = 1
) (
   input  logic            i_run,
   input  logic            i_we,
   input  logic [AW-1:0]   i_waddr,
   input  logic [XLEN-1:0] i_wdata,
   input  logic [AW-1:0]   i_raddr,
   input  logic [XLEN-1:0] i_mem [NREGS],
   output logic [XLEN-1:0] o_rdata
);

   localparam logic [AW:0] c_NREGS = (AW+1)'(NREGS);

   logic w_in_range;
   logic w_hit;

   // Entry 0 and addresses past the last entry always read as zero.
   assign w_in_range = (i_raddr != '0) && ({1'b0, i_raddr} < c_NREGS);
   assign w_hit      = (BYPASS != 0) && i_we && (i_waddr == i_raddr);

   always_comb begin
      o_rdata = '0;
      if (i_run && w_in_range) begin
         if (w_hit) begin
            o_rdata = i_wdata;
         end else begin
            o_rdata = i_mem[i_raddr];
         end
      end
   end

endmodule : regfile_read_port
`default_nettype wire

// File: rtl/regfile_multiport.sv
`default_nettype none
// ============================================================================
// Module   : regfile_multiport
// Brief    : NUM_RD-read / 1-write register file with sequential clear on reset
// Revision : 1.0
// ============================================================================
module regfile_multiport
   import regfile_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int NREGS  = 32,
   parameter int AW     = $clog2(NREGS),
   parameter int NUM_RD = 2,
   parameter int BYPASS = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   we,
   input  logic [AW-1:0]          waddr,
   input  logic [XLEN-1:0]        wdata,
   input  logic [NUM_RD*AW-1:0]   raddr,
   output logic [NUM_RD*XLEN-1:0] rdata,
   output logic                   ready
);

   localparam logic [AW:0]   c_NREGS = (AW+1)'(NREGS);
   localparam logic [AW-1:0] c_LAST  = AW'(NREGS - 1);

   generate
      if (NUM_RD < 1 || NUM_RD > MAX_RD) begin : g_bad_num_rd
         $error("regfile_multiport: NUM_RD must be in 1..%0d", MAX_RD);
      end
      if (NREGS < 2) begin : g_bad_nregs
         $error("regfile_multiport: NREGS must be at least 2");
      end
   endgenerate

   rf_state_e       r_state;
   logic [AW-1:0]   r_clr_ptr;
   logic            r_ready;
   logic [XLEN-1:0] r_mem [NREGS];

   logic            w_run;
   logic            w_wen;
   logic [AW-1:0]   w_waddr;
   logic [XLEN-1:0] w_wdata;

   assign w_run = (r_state == ST_RUN);
   assign ready = r_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= ST_CLEAR;
         r_clr_ptr <= '0;
         r_ready   <= 1'b0;
      end else begin
         case (r_state)
            ST_CLEAR: begin
               r_clr_ptr <= r_clr_ptr + 1'b1;
               if (r_clr_ptr == c_LAST) begin
                  r_state <= ST_RUN;
                  r_ready <= 1'b1;
               end
            end
            default: begin
               r_state <= ST_RUN;
            end
         endcase
      end
   end

   // The sweep owns the write port until the array is initialised.
   always_comb begin
      w_wen   = 1'b0;
      w_waddr = waddr;
      w_wdata = wdata;
      if (!reset) begin
         if (!w_run) begin
            w_wen   = 1'b1;
            w_waddr = r_clr_ptr;
            w_wdata = '0;
         end else begin
            w_wen = we && (waddr != '0) && ({1'b0, waddr} < c_NREGS);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_wen) begin
         r_mem[w_waddr] <= w_wdata;
      end
   end

   generate
      for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
         regfile_read_port #(
            .XLEN   (XLEN),
            .NREGS  (NREGS),
            .AW     (AW),
            .BYPASS (BYPASS)
         ) u_rd (
            .i_run   (w_run),
            .i_we    (we),
            .i_waddr (waddr),
            .i_wdata (wdata),
            .i_raddr (raddr[k*AW +: AW]),
            .i_mem   (r_mem),
            .o_rdata (rdata[k*XLEN +: XLEN])
         );
      end
   endgenerate

endmodule : regfile_multiport
`default_nettype wire

// File: tb/tb_regfile_multiport.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_multiport
// Brief    : Two builds (32x3 bypass, 24x2 no-bypass) against an array model
// Revision : 1.0
// ============================================================================
module tb_regfile_multiport;

   localparam int XLEN = 32;
   localparam int NA   = 32;
   localparam int NB   = 24;
   localparam int AW   = 5;
   localparam int RDA  = 3;
   localparam int RDB  = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                 reset, we;
   logic [AW-1:0]        waddr;
   logic [XLEN-1:0]      wdata;
   logic [RDA*AW-1:0]    raddr_a;
   logic [RDB*AW-1:0]    raddr_b;
   logic [RDA*XLEN-1:0]  rdata_a;
   logic [RDB*XLEN-1:0]  rdata_b;
   logic                 ready_a, ready_b;

   regfile_multiport #(.XLEN(XLEN), .NREGS(NA), .NUM_RD(RDA), .BYPASS(1)) u_dut_a (
      .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
      .raddr(raddr_a), .rdata(rdata_a), .ready(ready_a));

   regfile_multiport #(.XLEN(XLEN), .NREGS(NB), .NUM_RD(RDB), .BYPASS(0)) u_dut_b (
      .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
      .raddr(raddr_b), .rdata(rdata_b), .ready(ready_b));

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] mem_a [NA];
   logic [31:0] mem_b [NB];
   int          sweep_a = 0, sweep_b = 0;
   bit          rdy_a = 0, rdy_b = 0;
   bit          known = 0;

   function automatic logic [31:0] expect_rd(input bit is_b, input logic [4:0] a);
      int n   = is_b ? NB : NA;
      bit byp = !is_b;
      bit rdy = is_b ? rdy_b : rdy_a;
      if (!rdy || a == 0 || int'(a) >= n) return 32'h0;
      if (byp && we && waddr == a) return wdata;
      return is_b ? mem_b[a] : mem_a[a];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      for (int k = 0; k < RDA; k++)
         chk($sformatf("%s a.rd%0d", tag, k), rdata_a[k*XLEN +: XLEN], expect_rd(1'b0, raddr_a[k*AW +: AW]));
      for (int k = 0; k < RDB; k++)
         chk($sformatf("%s b.rd%0d", tag, k), rdata_b[k*XLEN +: XLEN], expect_rd(1'b1, raddr_b[k*AW +: AW]));
      chk({tag, " a.ready"}, {31'b0, ready_a}, {31'b0, rdy_a});
      chk({tag, " b.ready"}, {31'b0, ready_b}, {31'b0, rdy_b});
   endtask

   // Model: a reset restarts an N-cycle sweep that ignores writes and ends with all-zero contents.
   task automatic model_edge();
      if (reset) begin
         sweep_a = 0; rdy_a = 0;
         sweep_b = 0; rdy_b = 0;
      end else begin
         if (!rdy_a) begin
            sweep_a++;
            if (sweep_a == NA) begin
               rdy_a = 1;
               for (int i = 0; i < NA; i++) mem_a[i] = '0;
            end
         end else if (we && waddr != 0 && int'(waddr) < NA) begin
            mem_a[waddr] = wdata;
         end
         if (!rdy_b) begin
            sweep_b++;
            if (sweep_b == NB) begin
               rdy_b = 1;
               for (int i = 0; i < NB; i++) mem_b[i] = '0;
            end
         end else if (we && waddr != 0 && int'(waddr) < NB) begin
            mem_b[waddr] = wdata;
         end
      end
   endtask

   task automatic tick(input string tag);
      #1;
      if (known) check_all(tag);
      @(posedge clk);
      model_edge();
      known = 1;
      @(negedge clk);
   endtask

   task automatic set_rd(input int k, input logic [4:0] a);
      raddr_a[k*AW +: AW] = a;
      if (k < RDB) raddr_b[k*AW +: AW] = a;
   endtask

   task automatic set_all_rd(input logic [4:0] a);
      for (int k = 0; k < RDA; k++) set_rd(k, a);
   endtask

   initial begin
      int cyc_a, cyc_b;
      reset = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
      raddr_a = '0; raddr_b = '0;
      @(negedge clk);
      tick("rst");
      reset = 1'b0;

      // Sweep with junk writes that must be ignored
      cyc_a = -1; cyc_b = -1;
      for (int i = 1; i <= 34; i++) begin
         we    = (i <= 20);
         waddr = AW'($urandom);
         wdata = $urandom;
         for (int k = 0; k < RDA; k++) set_rd(k, AW'($urandom));
         tick("sweep");
         if (ready_a === 1'b1 && cyc_a < 0) cyc_a = i;
         if (ready_b === 1'b1 && cyc_b < 0) cyc_b = i;
      end
      chk("sweep len a", cyc_a, 32);
      chk("sweep len b", cyc_b, 24);

      // Write x5 then read on every port
      we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; set_all_rd(5'd0);
      tick("wr x5");
      we = 1'b0; set_all_rd(5'd5);
      #1;
      chk("x5 a.p0", rdata_a[0 +: 32], 32'hDEADBEEF);
      chk("x5 a.p1", rdata_a[32 +: 32], 32'hDEADBEEF);
      chk("x5 a.p2", rdata_a[64 +: 32], 32'hDEADBEEF);
      chk("x5 b.p1", rdata_b[32 +: 32], 32'hDEADBEEF);
      tick("rd x5");

      // x0 hardwired, including same-cycle bypass
      we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; set_all_rd(5'd0);
      #1;
      chk("x0 bypass", rdata_a[0 +: 32], 32'h0);
      tick("wr x0");
      we = 1'b0;
      #1;
      chk("x0 read", rdata_a[32 +: 32], 32'h0);
      tick("rd x0");

      // Bypass vs. no bypass
      we = 1'b1; waddr = 5'd7; wdata = 32'h12345678; set_all_rd(5'd7);
      #1;
      chk("bypass a", rdata_a[0 +: 32], 32'h12345678);
      chk("nobypass b", rdata_b[0 +: 32], 32'h0);
      tick("bypass");
      we = 1'b0;
      #1;
      chk("after wr b x7", rdata_b[0 +: 32], 32'h12345678);
      tick("rd x7");

      // Reset, write during sweep, reset again mid-sweep
      reset = 1'b1; tick("rst2");
      reset = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         we = (i == 5); waddr = 5'd3; wdata = 32'hAAAA5555; set_all_rd(5'd3);
         tick("sweep2");
      end
      we = 1'b0;
      reset = 1'b1; tick("rst mid");
      reset = 1'b0;
      cyc_a = -1; cyc_b = -1;
      for (int i = 1; i <= 40; i++) begin
         tick("sweep3");
         if (ready_a === 1'b1 && cyc_a < 0) cyc_a = i;
         if (ready_b === 1'b1 && cyc_b < 0) cyc_b = i;
      end
      chk("restart len a", cyc_a, 32);
      chk("restart len b", cyc_b, 24);
      set_rd(0, 5'd3); set_rd(1, 5'd5);
      #1;
      chk("x3 lost a", rdata_a[0 +: 32], 32'h0);
      chk("x3 lost b", rdata_b[0 +: 32], 32'h0);
      chk("x5 cleared a", rdata_a[32 +: 32], 32'h0);
      tick("rd x3");

      // Address 30: valid in the 32-entry build, dropped in the 24-entry build
      we = 1'b1; waddr = 5'd30; wdata = 32'hCAFEF00D; set_all_rd(5'd1);
      tick("wr x30");
      we = 1'b0; set_all_rd(5'd30);
      #1;
      chk("x30 a", rdata_a[0 +: 32], 32'hCAFEF00D);
      chk("x30 b", rdata_b[0 +: 32], 32'h0);
      tick("rd x30");

      // Random traffic with occasional resets
      for (int i = 0; i < 400; i++) begin
         reset = ($urandom_range(0, 199) == 0);
         we    = $urandom_range(0, 1);
         waddr = AW'($urandom_range(0, 31));
         wdata = $urandom;
         for (int k = 0; k < RDA; k++)
            set_rd(k, $urandom_range(0, 1) ? waddr : AW'($urandom_range(0, 31)));
         tick("rand");
      end
      reset = 1'b0; we = 1'b0;
      tick("final");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_regfile_multiport
`default_nettype wire
